bp_fe_mem_responder: RTL and testbench

- Synthesizable BedRock memory-side responder: the far end of the I$/UCE mem_cmd/mem_resp interface.
- Accepts one mem_cmd at a time, reads or writes an internal block-organised store, and returns a mem_resp after a programmable latency.
- Used as a lightweight backing memory for FE unit benches and small FPGA builds, in place of the DRAM-model memory.

---
 rtl/bp_fe_mem_responder_pkg.sv | 41 ++++
 rtl/bp_fe_mem_responder_if.sv | 41 ++++
 rtl/bp_fe_mem_responder_store.sv | 54 +++++
 rtl/bp_fe_mem_responder.sv | 115 +++++++++++
 tb/tb_bp_fe_mem_responder.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/bp_fe_mem_responder_pkg.sv
// Shared types and constants for the FE memory responder.
// Header struct widths match the default address/payload widths.
package bp_fe_mem_responder_pkg;

   localparam int block_offset_width_lp = 6;
   localparam logic [7:0] lfsr_seed_lp = 8'h5A;
   localparam int hdr_paddr_width_lp = 40;
   localparam int hdr_payload_width_lp = 16;

   typedef enum logic [1:0] {
      e_rd    = 2'd0,
      e_wr    = 2'd1,
      e_uc_rd = 2'd2,
      e_uc_wr = 2'd3
   } bp_fe_mem_msg_e;

   typedef struct packed {
      bp_fe_mem_msg_e msg_type;
      logic [2:0] size;
      logic [hdr_paddr_width_lp-1:0] addr;
      logic [hdr_payload_width_lp-1:0] payload;
   } bp_fe_mem_hdr_s;

   typedef enum logic [1:0] {
      e_idle = 2'd0,
      e_wait = 2'd1,
      e_resp = 2'd2
   } bp_fe_mem_state_e;

   function automatic logic [2:0] clamp_size(input logic [2:0] s);
      return (s > 3'd6) ? 3'd6 : s;
   endfunction

   // Low-bit mask covering 2^size bytes within a block
   function automatic logic [5:0] size_mask(input logic [2:0] s);
      logic [6:0] m;
      m = (7'd1 << clamp_size(s)) - 7'd1;
      return m[5:0];
   endfunction

endpackage

// File: rtl/bp_fe_mem_responder_if.sv
// mem_cmd / mem_resp bundle between a requester and the responder.
// Signal names are from the responder's point of view.
interface bp_fe_mem_responder_if #(
   parameter int paddr_width_p   = 40,
   parameter int block_width_p   = 512,
   parameter int payload_width_p = 16
);
   logic [1:0]                 mem_cmd_type_i;
   logic [2:0]                 mem_cmd_size_i;
   logic [paddr_width_p-1:0]   mem_cmd_addr_i;
   logic [payload_width_p-1:0] mem_cmd_payload_i;
   logic [block_width_p-1:0]   mem_cmd_data_i;
   logic                       mem_cmd_v_i;
   logic                       mem_cmd_ready_and_o;

   logic [1:0]                 mem_resp_type_o;
   logic [2:0]                 mem_resp_size_o;
   logic [paddr_width_p-1:0]   mem_resp_addr_o;
   logic [payload_width_p-1:0] mem_resp_payload_o;
   logic [block_width_p-1:0]   mem_resp_data_o;
   logic                       mem_resp_v_o;
   logic                       mem_resp_yumi_i;

   modport master (
      output mem_cmd_type_i, mem_cmd_size_i, mem_cmd_addr_i,
      output mem_cmd_payload_i, mem_cmd_data_i, mem_cmd_v_i,
      input  mem_cmd_ready_and_o,
      input  mem_resp_type_o, mem_resp_size_o, mem_resp_addr_o,
      input  mem_resp_payload_o, mem_resp_data_o, mem_resp_v_o,
      output mem_resp_yumi_i
   );

   modport slave (
      input  mem_cmd_type_i, mem_cmd_size_i, mem_cmd_addr_i,
      input  mem_cmd_payload_i, mem_cmd_data_i, mem_cmd_v_i,
      output mem_cmd_ready_and_o,
      output mem_resp_type_o, mem_resp_size_o, mem_resp_addr_o,
      output mem_resp_payload_o, mem_resp_data_o, mem_resp_v_o,
      input  mem_resp_yumi_i
   );
endinterface

// File: rtl/bp_fe_mem_responder_store.sv
// Block store: combinational read of the addressed block with uc_rd
// replication, byte-masked write on the clock edge. Never cleared.
module bp_fe_mem_responder_store
   import bp_fe_mem_responder_pkg::*;
#(
   parameter int block_width_p = 512,
   parameter int mem_els_p     = 1024,
   localparam int idx_width_lp = $clog2(mem_els_p)
) (
   input  logic                     clk_i,
   input  logic                     w_v_i,
   input  bp_fe_mem_msg_e           msg_type_i,
   input  logic [2:0]               size_i,
   input  logic [idx_width_lp-1:0]  idx_i,
   input  logic [5:0]               offset_i,
   input  logic [block_width_p-1:0] data_i,
   output logic [block_width_p-1:0] data_o
);
   localparam int bytes_lp = block_width_p / 8;

   logic [block_width_p-1:0] mem_r [mem_els_p];
   logic [block_width_p-1:0] blk;
   logic [bytes_lp-1:0]      be;
   logic [5:0]               mask;
   logic [5:0]               base;
   logic                     is_uc_rd;

   always_comb begin
      mask     = size_mask(size_i);
      base     = offset_i & ~mask;
      blk      = mem_r[idx_i];
      is_uc_rd = (msg_type_i == e_uc_rd);
      be       = '0;
      data_o   = blk;
      for (int j = 0; j < bytes_lp; j++) begin
         be[j] = (msg_type_i == e_wr)
               | ((msg_type_i == e_uc_wr)
                  & ((6'(j) & ~mask) == base));
         // Lane j of a uc_rd mirrors byte (j mod 2^size) of the window
         if (is_uc_rd)
            data_o[8*j +: 8] = blk[{base | (6'(j) & mask), 3'b000} +: 8];
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_v_i) begin
         for (int j = 0; j < bytes_lp; j++) begin
            if (be[j])
               mem_r[idx_i][8*j +: 8] <= data_i[8*j +: 8];
         end
      end
   end

endmodule

// File: rtl/bp_fe_mem_responder.sv
// FE backing-memory responder: one command at a time, response after latency.
// BP_FE_MEM_RESPONDER_RAND_LAT_EN: LFSR-drawn latency in 0..latency_p.
module bp_fe_mem_responder
   import bp_fe_mem_responder_pkg::*;
#(
   parameter int paddr_width_p   = 40,
   parameter int block_width_p   = 512,
   parameter int payload_width_p = 16,
   parameter int mem_els_p       = 1024,
   parameter int latency_p       = 4
) (
   input logic                  clk_i,
   input logic                  reset_i,
   bp_fe_mem_responder_if.slave mem_if
);
   localparam int idx_width_lp = $clog2(mem_els_p);

   bp_fe_mem_state_e         state_r, state_n;
   logic [7:0]               cnt_r, cnt_n;
   bp_fe_mem_hdr_s           hdr_r, hdr_n;
   logic [block_width_p-1:0] data_r, data_n;
   logic [block_width_p-1:0] store_data;
   logic [7:0]               lat_w;
   logic                     ready;
   logic                     accept;
   bp_fe_mem_msg_e           cmd_type;

   assign cmd_type = bp_fe_mem_msg_e'(mem_if.mem_cmd_type_i);
   assign ready    = (state_r == e_idle) & reset_i;
   assign accept   = ready & mem_if.mem_cmd_v_i;

   bp_fe_mem_responder_store #(
      .block_width_p(block_width_p),
      .mem_els_p    (mem_els_p)
   ) store (
      .clk_i     (clk_i),
      .w_v_i     (accept),
      .msg_type_i(cmd_type),
      .size_i    (mem_if.mem_cmd_size_i),
      .idx_i     (mem_if.mem_cmd_addr_i[block_offset_width_lp +: idx_width_lp]),
      .offset_i  (mem_if.mem_cmd_addr_i[block_offset_width_lp-1:0]),
      .data_i    (mem_if.mem_cmd_data_i),
      .data_o    (store_data)
   );

`ifdef BP_FE_MEM_RESPONDER_RAND_LAT_EN
   logic [7:0] lfsr_r;

   // x^8 + x^6 + x^5 + x^4 + 1
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i)
         lfsr_r <= lfsr_seed_lp;
      else if (accept)
         lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
   end

   assign lat_w = 8'({1'b0, lfsr_r} % 9'(latency_p + 1));
`else
   assign lat_w = 8'(latency_p);
`endif

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_r <= e_idle;
         cnt_r   <= '0;
         hdr_r   <= '0;
         data_r  <= '0;
      end else begin
         state_r <= state_n;
         cnt_r   <= cnt_n;
         hdr_r   <= hdr_n;
         data_r  <= data_n;
      end
   end

   always_comb begin
      state_n = state_r;
      cnt_n   = cnt_r;
      hdr_n   = hdr_r;
      data_n  = data_r;
      unique case (state_r)
         e_idle: begin
            if (accept) begin
               hdr_n.msg_type = cmd_type;
               hdr_n.size     = mem_if.mem_cmd_size_i;
               hdr_n.addr     = hdr_paddr_width_lp'(mem_if.mem_cmd_addr_i);
               hdr_n.payload  = hdr_payload_width_lp'(mem_if.mem_cmd_payload_i);
               data_n = ((cmd_type == e_rd) || (cmd_type == e_uc_rd))
                      ? store_data : '0;
               cnt_n   = lat_w;
               state_n = (lat_w == 8'd0) ? e_resp : e_wait;
            end
         end
         e_wait: begin
            cnt_n = cnt_r - 8'd1;
            if (cnt_r == 8'd1)
               state_n = e_resp;
         end
         e_resp: begin
            if (mem_if.mem_resp_yumi_i)
               state_n = e_idle;
         end
         default: state_n = e_idle;
      endcase
   end

   assign mem_if.mem_cmd_ready_and_o = ready;
   assign mem_if.mem_resp_v_o        = (state_r == e_resp);
   assign mem_if.mem_resp_type_o     = hdr_r.msg_type;
   assign mem_if.mem_resp_size_o     = hdr_r.size;
   assign mem_if.mem_resp_addr_o     = paddr_width_p'(hdr_r.addr);
   assign mem_if.mem_resp_payload_o  = payload_width_p'(hdr_r.payload);
   assign mem_if.mem_resp_data_o     = data_r;

endmodule

// File: tb/tb_bp_fe_mem_responder.sv
// Scoreboard bench: latency-4 and latency-0 responders side by side.
module tb_bp_fe_mem_responder;
   import bp_fe_mem_responder_pkg::*;

   typedef struct {
      logic [1:0]   t;
      logic [2:0]   sz;
      logic [39:0]  a;
      logic [15:0]  p;
      logic [511:0] d;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   bp_fe_mem_responder_if #(.paddr_width_p(40), .block_width_p(512),
                            .payload_width_p(16)) ifa ();
   bp_fe_mem_responder_if #(.paddr_width_p(40), .block_width_p(512),
                            .payload_width_p(16)) ifb ();

   bp_fe_mem_responder #(.mem_els_p(1024), .latency_p(4)) u_dut_a (
      .clk_i  (clk),
      .reset_i(rst_n),
      .mem_if (ifa)
   );

   bp_fe_mem_responder #(.mem_els_p(1024), .latency_p(0)) u_dut_b (
      .clk_i  (clk),
      .reset_i(rst_n),
      .mem_if (ifb)
   );

   task automatic check(input string tag, input logic [511:0] got,
                        input logic [511:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic drive_a(input logic [1:0] t, input logic [2:0] sz,
                          input logic [39:0] a, input logic [15:0] p,
                          input logic [511:0] din);
      ifa.mem_cmd_type_i    = t;
      ifa.mem_cmd_size_i    = sz;
      ifa.mem_cmd_addr_i    = a;
      ifa.mem_cmd_payload_i = p;
      ifa.mem_cmd_data_i    = din;
      ifa.mem_cmd_v_i       = 1'b1;
   endtask

   task automatic issue(input logic [1:0] t, input logic [2:0] sz,
                        input logic [39:0] a, input logic [15:0] p,
                        input logic [511:0] din, input logic [511:0] dexp,
                        input int hold);
      exp_t e;
      int n;
      e = '{t: t, sz: sz, a: a, p: p, d: dexp};
      sb_q.push_back(e);
      @(negedge clk);
      drive_a(t, sz, a, p, din);
      n = 0;
      while (!ifa.mem_cmd_ready_and_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("accept_ready", ifa.mem_cmd_ready_and_o, 1);
      @(posedge clk);
      #1 ifa.mem_cmd_v_i = 1'b0;
      n = 0;
      while (!ifa.mem_resp_v_o && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("latency", n, 4);
      e = sb_q.pop_front();
      check("resp_type", ifa.mem_resp_type_o, e.t);
      check("resp_size", ifa.mem_resp_size_o, e.sz);
      check("resp_addr", ifa.mem_resp_addr_o, e.a);
      check("resp_payload", ifa.mem_resp_payload_o, e.p);
      check("resp_data", ifa.mem_resp_data_o, e.d);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check("hold_v", ifa.mem_resp_v_o, 1);
         check("hold_ready", ifa.mem_cmd_ready_and_o, 0);
         check("hold_addr", ifa.mem_resp_addr_o, e.a);
         check("hold_payload", ifa.mem_resp_payload_o, e.p);
         check("hold_data", ifa.mem_resp_data_o, e.d);
      end
      @(negedge clk) ifa.mem_resp_yumi_i = 1'b1;
      @(posedge clk);
      #1 ifa.mem_resp_yumi_i = 1'b0;
      check("post_yumi_v", ifa.mem_resp_v_o, 0);
      check("post_yumi_ready", ifa.mem_cmd_ready_and_o, 1);
   endtask

   logic [511:0] inc_blk, inc_mod, pat;
   int           n0;
   bit           stale;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 64; i++) inc_blk[8*i +: 8] = 8'(i);
      inc_mod = inc_blk;
      inc_mod[8*3 +: 8] = 8'hA5;
      for (int i = 0; i < 16; i++) pat[32*i +: 32] = 32'hC0DE0000 + 32'(i);

      ifa.mem_cmd_v_i = 1'b0;
      ifa.mem_resp_yumi_i = 1'b0;
      ifa.mem_cmd_type_i = '0;
      ifa.mem_cmd_size_i = '0;
      ifa.mem_cmd_addr_i = '0;
      ifa.mem_cmd_payload_i = '0;
      ifa.mem_cmd_data_i = '0;
      ifb.mem_cmd_v_i = 1'b0;
      ifb.mem_resp_yumi_i = 1'b0;
      ifb.mem_cmd_type_i = '0;
      ifb.mem_cmd_size_i = '0;
      ifb.mem_cmd_addr_i = '0;
      ifb.mem_cmd_payload_i = '0;
      ifb.mem_cmd_data_i = '0;

      #3 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", ifa.mem_cmd_ready_and_o, 0);
      check("rst_v", ifa.mem_resp_v_o, 0);
      check("rst_data", ifa.mem_resp_data_o, 0);
      check("rst_addr", ifa.mem_resp_addr_o, 0);
      check("rst_payload", ifa.mem_resp_payload_o, 0);
      @(negedge clk) rst_n = 1'b1;
      #1 check("rst_rel_ready", ifa.mem_cmd_ready_and_o, 1);

      // uncached word write then read back replicated
      issue(2'd3, 3'd2, 40'h1004, 16'h0011, {16{32'hDEADBEEF}}, '0, 0);
      issue(2'd2, 3'd2, 40'h1004, 16'h0022, '0, {16{32'hDEADBEEF}}, 0);

      // full block write, unrotated read at nonzero offset
      issue(2'd1, 3'd6, 40'h2000, 16'h0033, inc_blk, '0, 0);
      issue(2'd0, 3'd6, 40'h2020, 16'h0044, '0, inc_blk, 10);

      // byte-granular uncached accesses and size clamping
      issue(2'd3, 3'd0, 40'h2003, 16'h0055, {64{8'hA5}}, '0, 0);
      issue(2'd0, 3'd6, 40'h2000, 16'h0066, '0, inc_mod, 0);
      issue(2'd2, 3'd0, 40'h2025, 16'h0077, '0, {64{8'h25}}, 0);
      issue(2'd2, 3'd3, 40'h200D, 16'h0088, '0,
            {8{64'h0F0E0D0C0B0A0908}}, 0);
      issue(2'd2, 3'd7, 40'h2010, 16'h0099, '0, inc_mod, 0);

      // index wraps modulo mem_els_p
      issue(2'd1, 3'd6, 40'h0, 16'h00AA, pat, '0, 0);
      issue(2'd0, 3'd6, 40'h10000, 16'h00BB, '0, pat, 0);

      // reset while waiting: write stays, response is dropped
      @(negedge clk);
      drive_a(2'd3, 3'd0, 40'h3001, 16'h00CC, {64{8'h77}});
      @(posedge clk);
      #1 ifa.mem_cmd_v_i = 1'b0;
      @(posedge clk);
      @(negedge clk) rst_n = 1'b0;
      #1;
      check("midrst_v", ifa.mem_resp_v_o, 0);
      check("midrst_ready", ifa.mem_cmd_ready_and_o, 0);
      check("midrst_addr", ifa.mem_resp_addr_o, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      #1 check("midrst_rel_ready", ifa.mem_cmd_ready_and_o, 1);
      stale = 1'b0;
      repeat (8) begin
         @(posedge clk);
         #1 if (ifa.mem_resp_v_o) stale = 1'b1;
      end
      check("midrst_no_stale", stale, 0);
      issue(2'd2, 3'd0, 40'h3001, 16'h00DD, '0, {64{8'h77}}, 0);
      issue(2'd0, 3'd6, 40'h2000, 16'h00EE, '0, inc_mod, 0);

      // zero latency: response the cycle after accept
      sb_q.push_back('{t: 2'd1, sz: 3'd6, a: 40'h40, p: 16'h0101, d: '0});
      @(negedge clk);
      ifb.mem_cmd_type_i = 2'd1;
      ifb.mem_cmd_size_i = 3'd6;
      ifb.mem_cmd_addr_i = 40'h40;
      ifb.mem_cmd_payload_i = 16'h0101;
      ifb.mem_cmd_data_i = pat;
      ifb.mem_cmd_v_i = 1'b1;
      #1 check("b_ready", ifb.mem_cmd_ready_and_o, 1);
      @(posedge clk);
      #1 ifb.mem_cmd_v_i = 1'b0;
      check("b_lat0_v_wr", ifb.mem_resp_v_o, 1);
      begin
         exp_t e;
         e = sb_q.pop_front();
         check("b_wr_payload", ifb.mem_resp_payload_o, e.p);
         check("b_wr_data", ifb.mem_resp_data_o, e.d);
      end
      @(negedge clk) ifb.mem_resp_yumi_i = 1'b1;
      @(posedge clk);
      #1 ifb.mem_resp_yumi_i = 1'b0;
      sb_q.push_back('{t: 2'd0, sz: 3'd6, a: 40'h40, p: 16'h0202, d: pat});
      @(negedge clk);
      ifb.mem_cmd_type_i = 2'd0;
      ifb.mem_cmd_payload_i = 16'h0202;
      ifb.mem_cmd_v_i = 1'b1;
      @(posedge clk);
      #1 ifb.mem_cmd_v_i = 1'b0;
      check("b_lat0_v_rd", ifb.mem_resp_v_o, 1);
      begin
         exp_t e;
         e = sb_q.pop_front();
         check("b_rd_type", ifb.mem_resp_type_o, e.t);
         check("b_rd_payload", ifb.mem_resp_payload_o, e.p);
         check("b_rd_data", ifb.mem_resp_data_o, e.d);
      end
      @(negedge clk) ifb.mem_resp_yumi_i = 1'b1;
      @(posedge clk);
      #1 ifb.mem_resp_yumi_i = 1'b0;
      n0 = sb_q.size();
      check("sb_empty", n0, 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
